// File: rtl/seg_scan_arbiter_if.sv
// Bus bundle for seg_scan_arbiter: two requester handshakes plus the display outputs.
// The master side drives requests and data; the slave side is the arbiter.
interface seg_scan_arbiter_if;
    logic        cpu_req;
    logic [15:0] cpu_data;
    logic        cpu_gnt;
    logic        kb_req;
    logic [7:0]  kb_data;
    logic        kb_gnt;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [15:0] disp_val;
    logic        src;

    modport master (
        output cpu_req, cpu_data, kb_req, kb_data,
        input  cpu_gnt, kb_gnt, seg, an, disp_val, src
    );

    modport slave (
        input  cpu_req, cpu_data, kb_req, kb_data,
        output cpu_gnt, kb_gnt, seg, an, disp_val, src
    );
endinterface

// File: rtl/seg_scan_arbiter.sv
// Round-robin arbiter (CPU vs keyboard) feeding a 4-digit multiplexed 7-segment scanner.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (least significant always shown).
module seg_scan_arbiter #(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned GUARD_CYCLES = 16
) (
    input logic              clk,
    input logic              rst,
    seg_scan_arbiter_if.slave bus
);

    localparam int unsigned CntW = 21;

    typedef enum logic {StGuard, StDrive} state_e;

    state_e          state_q;
    logic [1:0]      idx_q;
    logic [CntW-1:0] cnt_q;
    logic [3:0]      an_q;
    logic [6:0]      seg_q;

    logic        cpu_gnt_q;
    logic        kb_gnt_q;
    logic        rr_kb_q;
    logic        src_q;
    logic [15:0] disp_q;

    logic cpu_elig, kb_elig, grant_cpu, grant_kb;

    // A requester is deaf during its own grant cycle; ties go to whoever was not served last.
    always_comb begin
        cpu_elig  = bus.cpu_req & ~cpu_gnt_q;
        kb_elig   = bus.kb_req & ~kb_gnt_q;
        grant_cpu = cpu_elig & (~kb_elig | ~rr_kb_q);
        grant_kb  = kb_elig & ~grant_cpu;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_gnt_q <= 1'b0;
            kb_gnt_q  <= 1'b0;
            rr_kb_q   <= 1'b0;
            src_q     <= 1'b0;
            disp_q    <= 16'h0000;
        end else begin
            cpu_gnt_q <= grant_cpu;
            kb_gnt_q  <= grant_kb;
            if (grant_cpu) begin
                disp_q  <= bus.cpu_data;
                src_q   <= 1'b0;
                rr_kb_q <= 1'b1;
            end else if (grant_kb) begin
                disp_q  <= {8'h00, bus.kb_data};
                src_q   <= 1'b1;
                rr_kb_q <= 1'b0;
            end
        end
    end

    logic [3:0] nibble;
    logic [6:0] glyph;
    logic [3:0] an_sel;
    logic       blank;
    logic [3:0] drive_an;
    logic [6:0] drive_seg;

    always_comb begin
        unique case (idx_q)
            2'd0:    nibble = disp_q[15:12];
            2'd1:    nibble = disp_q[11:8];
            2'd2:    nibble = disp_q[7:4];
            default: nibble = disp_q[3:0];
        endcase
    end

    always_comb begin
        unique case (nibble)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h18;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h27;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            default: glyph = 7'h0E;
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        unique case (idx_q)
            2'd0:    blank = (disp_q[15:12] == 4'h0);
            2'd1:    blank = (disp_q[15:8] == 8'h00);
            2'd2:    blank = (disp_q[15:4] == 12'h000);
            default: blank = 1'b0;
        endcase
    end
`else
    assign blank = 1'b0;
`endif

    // idx 0 drives an[3], idx 3 drives an[0]
    assign an_sel    = ~(4'b1000 >> idx_q);
    assign drive_an  = blank ? 4'b1111 : an_sel;
    assign drive_seg = blank ? 7'h7F : glyph;

    // Outputs are loaded with the next state's value so the registered an/seg line up with state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StGuard;
            idx_q   <= 2'd0;
            cnt_q   <= '0;
            an_q    <= 4'b1111;
            seg_q   <= 7'h7F;
        end else begin
            unique case (state_q)
                StGuard: begin
                    if (cnt_q == CntW'(GUARD_CYCLES - 1)) begin
                        state_q <= StDrive;
                        cnt_q   <= '0;
                        an_q    <= drive_an;
                        seg_q   <= drive_seg;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        an_q  <= 4'b1111;
                        seg_q <= 7'h7F;
                    end
                end
                default: begin
                    if (cnt_q == CntW'(SCAN_DIV - 1)) begin
                        state_q <= StGuard;
                        cnt_q   <= '0;
                        idx_q   <= idx_q + 2'd1;
                        an_q    <= 4'b1111;
                        seg_q   <= 7'h7F;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        an_q  <= drive_an;
                        seg_q <= drive_seg;
                    end
                end
            endcase
        end
    end

    assign bus.cpu_gnt  = cpu_gnt_q;
    assign bus.kb_gnt   = kb_gnt_q;
    assign bus.disp_val = disp_q;
    assign bus.src      = src_q;
    assign bus.an       = an_q;
    assign bus.seg      = seg_q;

endmodule

// File: tb/tb_seg_scan_arbiter.sv
// Scoreboard bench for seg_scan_arbiter (SCAN_DIV=4, GUARD_CYCLES=2): grant and scan-window
// expectations are queued by the stimulus and popped by a negedge monitor.
module tb_seg_scan_arbiter;

    typedef struct {
        logic        is_kb;
        logic [15:0] val;
    } gnt_t;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        int         len;
    } win_t;

    logic clk;
    logic rst;
    seg_scan_arbiter_if bus ();

    seg_scan_arbiter #(
        .SCAN_DIV     (4),
        .GUARD_CYCLES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   checks;
    int   errors;
    gnt_t gnt_q[$];
    win_t scan_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic push_gnt(input logic is_kb, input logic [15:0] val);
        gnt_t g;
        g.is_kb = is_kb;
        g.val   = val;
        gnt_q.push_back(g);
    endtask

    task automatic push_win(input logic [3:0] an, input logic [6:0] seg, input int len);
        win_t w;
        w.an  = an;
        w.seg = seg;
        w.len = len;
        scan_q.push_back(w);
    endtask

    task automatic push_scan(input logic [6:0] g0, input logic [6:0] g1,
                             input logic [6:0] g2, input logic [6:0] g3);
        push_win(4'b1111, 7'h7F, 2); push_win(4'b0111, g0, 4);
        push_win(4'b1111, 7'h7F, 2); push_win(4'b1011, g1, 4);
        push_win(4'b1111, 7'h7F, 2); push_win(4'b1101, g2, 4);
        push_win(4'b1111, 7'h7F, 2); push_win(4'b1110, g3, 4);
    endtask

    task automatic release_rst();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((scan_q.size() > 0 || gnt_q.size() > 0) && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (scan_q.size() > 0 || gnt_q.size() > 0) begin
            errors++;
            $display("FAIL timeout pending_scan=%0d pending_gnt=%0d expected=0",
                     scan_q.size(), gnt_q.size());
            scan_q.delete();
            gnt_q.delete();
        end
    endtask

    // Grant monitor
    initial begin
        gnt_t g;
        forever begin
            @(negedge clk);
            if (bus.cpu_gnt && bus.kb_gnt) begin
                checks++;
                errors++;
                $display("FAIL both_gnt actual=11 expected=one-hot");
            end else if (bus.cpu_gnt || bus.kb_gnt) begin
                checks++;
                if (gnt_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_grant actual cpu=%b kb=%b expected none",
                             bus.cpu_gnt, bus.kb_gnt);
                end else begin
                    g = gnt_q.pop_front();
                    if (bus.kb_gnt !== g.is_kb || bus.disp_val !== g.val
                        || bus.src !== g.is_kb) begin
                        errors++;
                        $display("FAIL grant actual kb=%b val=%h src=%b expected kb=%b val=%h src=%b",
                                 bus.kb_gnt, bus.disp_val, bus.src, g.is_kb, g.val, g.is_kb);
                    end
                end
            end
        end
    end

    // Scan monitor: measures each run of a constant an value and compares whole windows
    initial begin
        logic [3:0] run_an;
        logic [6:0] run_seg;
        int         run_len;
        logic       seg_bad;
        win_t       w;
        run_len = 0;
        run_an  = '0;
        run_seg = '0;
        seg_bad = 1'b0;
        forever begin
            @(negedge clk);
            if (rst || scan_q.size() == 0) begin
                run_len = 0;
            end else if (run_len == 0) begin
                run_an  = bus.an;
                run_seg = bus.seg;
                run_len = 1;
                seg_bad = 1'b0;
            end else if (bus.an != run_an) begin
                w = scan_q.pop_front();
                checks++;
                if (run_an !== w.an || run_seg !== w.seg || run_len != w.len || seg_bad) begin
                    errors++;
                    $display("FAIL scan_window actual an=%b seg=%h len=%0d seg_changed=%b expected an=%b seg=%h len=%0d",
                             run_an, run_seg, run_len, seg_bad, w.an, w.seg, w.len);
                end
                run_an  = bus.an;
                run_seg = bus.seg;
                run_len = 1;
                seg_bad = 1'b0;
            end else begin
                run_len++;
                if (bus.seg != run_seg) seg_bad = 1'b1;
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.cpu_req  = 1'b0;
        bus.cpu_data = 16'h0000;
        bus.kb_req   = 1'b0;
        bus.kb_data  = 8'h00;

        // Reset values, then idle scan of zeros
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cpu_gnt", {31'd0, bus.cpu_gnt}, 32'd0);
        chk("rst_kb_gnt", {31'd0, bus.kb_gnt}, 32'd0);
        chk("rst_disp_val", {16'd0, bus.disp_val}, 32'h0000);
        chk("rst_src", {31'd0, bus.src}, 32'd0);
        chk("rst_an", {28'd0, bus.an}, 32'hF);
        chk("rst_seg", {25'd0, bus.seg}, 32'h7F);
        push_scan(7'h40, 7'h40, 7'h40, 7'h40);
        release_rst();
        wait_done();

        // Single CPU load shows 1A2F
        rst = 1'b1;
        bus.cpu_req  = 1'b1;
        bus.cpu_data = 16'h1A2F;
        push_gnt(1'b0, 16'h1A2F);
        push_scan(7'h79, 7'h08, 7'h24, 7'h0E);
        release_rst();
        @(posedge clk);
        #1 bus.cpu_req = 1'b0;
        wait_done();

        // Simultaneous requests and round-robin alternation
        rst = 1'b1;
        bus.cpu_req  = 1'b1;
        bus.cpu_data = 16'h1234;
        bus.kb_req   = 1'b1;
        bus.kb_data  = 8'h5C;
        push_gnt(1'b0, 16'h1234);
        push_gnt(1'b1, 16'h005C);
        release_rst();
        @(posedge clk);
        #1 bus.cpu_req = 1'b0;
        @(posedge clk);
        #1 bus.kb_req = 1'b0;
        chk("final_disp_val", {16'd0, bus.disp_val}, 32'h005C);
        chk("final_src", {31'd0, bus.src}, 32'd1);
        bus.cpu_req  = 1'b1;
        bus.cpu_data = 16'hAAAA;
        push_gnt(1'b0, 16'hAAAA);
        @(posedge clk);
        #1 bus.cpu_req = 1'b0;
        @(posedge clk);
        #1;
        bus.cpu_req  = 1'b1;
        bus.cpu_data = 16'hBBBB;
        bus.kb_req   = 1'b1;
        bus.kb_data  = 8'h77;
        push_gnt(1'b1, 16'h0077);
        push_gnt(1'b0, 16'hBBBB);
        @(posedge clk);
        #1 bus.kb_req = 1'b0;
        @(posedge clk);
        #1 bus.cpu_req = 1'b0;
        wait_done();

        // Reset during a keyboard grant
        rst = 1'b1;
        bus.kb_req  = 1'b1;
        bus.kb_data = 8'h99;
        release_rst();
        @(posedge clk);
        #1;
        chk("kb_gnt_before_rst", {31'd0, bus.kb_gnt}, 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_kb_gnt", {31'd0, bus.kb_gnt}, 32'd0);
        chk("abort_disp_val", {16'd0, bus.disp_val}, 32'h0000);
        chk("abort_an", {28'd0, bus.an}, 32'hF);
        chk("abort_src", {31'd0, bus.src}, 32'd0);
        repeat (2) @(posedge clk);
        push_gnt(1'b1, 16'h0099);
        release_rst();
        @(posedge clk);
        #1 bus.kb_req = 1'b0;
        wait_done();

        // Small value: leading digits blanked only when the option is built in
        rst = 1'b1;
        bus.cpu_req  = 1'b1;
        bus.cpu_data = 16'h0007;
        push_gnt(1'b0, 16'h0007);
`ifdef LEADING_ZERO_BLANK_EN
        push_win(4'b1111, 7'h7F, 20);
        push_win(4'b1110, 7'h78, 4);
`else
        push_scan(7'h40, 7'h40, 7'h40, 7'h78);
`endif
        release_rst();
        @(posedge clk);
        #1 bus.cpu_req = 1'b0;
        wait_done();

`ifdef LEADING_ZERO_BLANK_EN
        rst = 1'b1;
        push_win(4'b1111, 7'h7F, 20);
        push_win(4'b1110, 7'h40, 4);
        release_rst();
        wait_done();
`endif

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
